// File: rtl/pdm_modulator.sv
// First-order delta-sigma PDM modulator with linear interpolation of 8-bit PCM input, OSR bits per sample.
// Latency: a sample is loaded at the next frame-load edge. It affects PDM_OUT from the following edge.
// Backpressure: S_READY is low while the input FIFO is full. It comes from the registered count only.
module pdm_modulator #(
  parameter int DATA_W     = 8,
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic              PDM_OUT,
  output logic              UNDERRUN,
  input  logic              UNDERRUN_CLR
);

  localparam int W     = DATA_W + OSR_LOG2;
  localparam int SW    = W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic                pdm_q, pdm_d;
  logic                und_q, und_d;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                s_ready;
  logic                push;
  logic                pop;
  logic                load;
  logic                fifo_nempty;

  logic signed [DATA_W:0] diff;
  logic signed [SW-1:0]   v_s;
  logic [W-1:0]           v_u;
  logic [W:0]             sum;
  logic                   unused_v;

  assign s_ready  = (cnt_q < DEPTH_C);
  assign S_READY  = s_ready;
  assign PDM_OUT  = pdm_q;
  assign UNDERRUN = und_q;

  // Interpolated level between prev and cur, plus the delta-sigma accumulator add.
  always_comb begin
    diff = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
    v_s  = $signed({2'b00, prev_q, {OSR_LOG2{1'b0}}})
         + $signed({{(OSR_LOG2+1){diff[DATA_W]}}, diff})
         * $signed({{(DATA_W+2){1'b0}}, phase_q});
    // The interpolated value never leaves 0..(2**DATA_W-1)*OSR, so the top two bits are always zero.
    v_u      = v_s[W-1:0];
    unused_v = ^v_s[SW-1:W];
    sum      = {1'b0, acc_q} + {1'b0, v_u};
  end

  // Next-state logic for the run/idle control, the frame loads, the sticky flag and the FIFO.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    pdm_d    = pdm_q;
    und_d    = und_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    fifo_nempty = (cnt_q != '0);
    push        = S_VALID && s_ready;
    // A frame load uses the FIFO as it was before this edge, so a same-edge push is not seen.
    load        = EN && ((state_q == IDLE) ? fifo_nempty : (&phase_q));
    pop         = load && fifo_nempty;

    if (!EN) begin
      // Disabling drops the rest of the frame. The next start ramps up from zero again.
      state_d = IDLE;
      phase_d = '0;
      acc_d   = '0;
      prev_d  = '0;
      cur_d   = '0;
      pdm_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (fifo_nempty) begin
        state_d = RUN;
      end
    end else begin
      phase_d = phase_q + OSR_LOG2'(1);
      acc_d   = sum[W-1:0];
      pdm_d   = sum[W];
    end

    if (load) begin
      prev_d = cur_q;
      if (fifo_nempty) begin
        cur_d = mem_q[rd_ptr_q];
      end
    end

    // A new underrun takes priority over a clear request on the same edge.
    if (load && !fifo_nempty) begin
      und_d = 1'b1;
    end else if (UNDERRUN_CLR) begin
      und_d = 1'b0;
    end

    if (push) begin
      mem_d[wr_ptr_q] = S_DATA;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers. Reset clears everything, including the FIFO contents.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      acc_q    <= '0;
      prev_q   <= '0;
      cur_q    <= '0;
      pdm_q    <= 1'b0;
      und_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      pdm_q    <= pdm_d;
      und_q    <= und_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed plus randomized bench for pdm_modulator.
// A frame-level arithmetic reference model predicts every output bit and checks per-frame ones counts.
// Inputs are driven on the falling edge, and outputs are checked on the falling edge.
module tb_pdm_modulator;

  localparam int OSR  = 64;
  localparam int FULL = 16384;
  localparam int FD   = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] S_DATA = 8'd0;
  logic       S_VALID = 1'b0;
  logic       UNDERRUN_CLR = 1'b0;
  logic       S_READY;
  logic       PDM_OUT;
  logic       UNDERRUN;

  int n_cmp = 0;
  int n_bad = 0;

  pdm_modulator #(.DATA_W(8), .OSR_LOG2(6), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .PDM_OUT(PDM_OUT), .UNDERRUN(UNDERRUN),
    .UNDERRUN_CLR(UNDERRUN_CLR)
  );

  always #5 CLK = ~CLK;

  // Reference model: a sample queue, a frame position, the interpolated level and an integer accumulator.
  int mq[$];
  bit m_run, m_pdm, m_und, m_stepped, m_fend, m_abort;
  int m_phase, m_acc, m_prev, m_cur, m_fprev, m_fcur;

  always @(posedge CLK or negedge RST) begin : model
    int n, v, s;
    bit push, load;
    if (!RST) begin
      mq.delete();
      m_run = 0; m_pdm = 0; m_und = 0; m_stepped = 0; m_fend = 0; m_abort = 1;
      m_phase = 0; m_acc = 0; m_prev = 0; m_cur = 0;
    end else begin
      n = mq.size();
      push = S_VALID && (n < FD);
      load = EN && (m_run ? (m_phase == OSR - 1) : (n > 0));
      m_stepped = 0; m_fend = 0; m_abort = !EN;
      if (!EN) begin
        m_run = 0; m_phase = 0; m_acc = 0; m_prev = 0; m_cur = 0; m_pdm = 0;
      end else if (!m_run) begin
        m_run = (n > 0);
      end else begin
        v = m_prev * OSR + (m_cur - m_prev) * m_phase;
        s = m_acc + v;
        m_pdm = (s >= FULL);
        m_acc = s % FULL;
        m_stepped = 1;
        m_fend = (m_phase == OSR - 1);
        m_fprev = m_prev; m_fcur = m_cur;
        m_phase = (m_phase + 1) % OSR;
      end
      if (load) begin
        m_prev = m_cur;
        if (n > 0) m_cur = mq.pop_front();
      end
      if (load && n == 0) m_und = 1;
      else if (UNDERRUN_CLR) m_und = 0;
      if (push) mq.push_back(S_DATA);
    end
  end

  // Per-frame ones counts taken from the DUT output, labelled with the model's prev and cur values.
  int fr_ones[$];
  int fr_prev[$];
  int fr_cur[$];
  int dut_ones = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    chk("pdm", PDM_OUT, m_pdm);
    chk("ready", S_READY, mq.size() < FD);
    chk("underrun", UNDERRUN, m_und);
    if (m_abort) dut_ones = 0;
    if (m_stepped) dut_ones += int'(PDM_OUT);
    if (m_fend) begin
      fr_ones.push_back(dut_ones);
      fr_prev.push_back(m_fprev);
      fr_cur.push_back(m_fcur);
      dut_ones = 0;
    end
  endtask

  task automatic run_frames(input int n);
    int start = fr_ones.size();
    int k = 0;
    while (fr_ones.size() < start + n && k < n * OSR + 200) begin
      step();
      k++;
    end
    chk_rng("frame_timeout", fr_ones.size() - start, n, n);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; EN = 1'b0; S_VALID = 1'b0; UNDERRUN_CLR = 1'b0;
    step();
    step();
    RST = 1'b1;
    fr_ones.delete(); fr_prev.delete(); fr_cur.delete();
    dut_ones = 0;
  endtask

  task automatic push_one(input logic [7:0] d);
    bit took = 0;
    int k = 0;
    S_VALID = 1'b1;
    S_DATA = d;
    while (!took && k < 300) begin
      took = S_READY;
      step();
      k++;
    end
    chk("push_done", took, 1'b1);
    S_VALID = 1'b0;
  endtask

  // Steady frames hold s/4 ones, rounded either way. Four consecutive steady frames hold exactly s ones.
  task automatic check_frames();
    int lo, hi, sum, s;
    bit same;
    for (int i = 0; i < fr_ones.size(); i++) begin
      if (fr_prev[i] == fr_cur[i]) begin
        lo = fr_cur[i] / 4;
        hi = lo + (((fr_cur[i] % 4) != 0) ? 1 : 0);
        chk_rng("steady_frame", fr_ones[i], lo, hi);
      end
    end
    for (int i = 0; i + 3 < fr_ones.size(); i++) begin
      s = fr_cur[i];
      same = 1;
      sum = 0;
      for (int j = i; j < i + 4; j++) begin
        if (fr_prev[j] != s || fr_cur[j] != s) same = 0;
        sum += fr_ones[j];
      end
      if (same) chk_rng("window4", sum, s, s);
    end
    fr_ones.delete(); fr_prev.delete(); fr_cur.delete();
  endtask

  initial begin : stim
    bit prevbit;

    // Power-up reset, then a run that sets UNDERRUN, then an asynchronous reset in the middle of a cycle.
    do_reset();
    chk("rst_pdm", PDM_OUT, 1'b0);
    chk("rst_ready", S_READY, 1'b1);
    chk("rst_und", UNDERRUN, 1'b0);
    push_one(8'd180);
    EN = 1'b1;
    repeat (150) step();
    chk("pre_rst_und", UNDERRUN, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("async_pdm", PDM_OUT, 1'b0);
    chk("async_ready", S_READY, 1'b1);
    chk("async_und", UNDERRUN, 1'b0);
    @(negedge CLK);
    step();
    RST = 1'b1;
    fr_ones.delete(); fr_prev.delete(); fr_cur.delete();
    dut_ones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle_empty_pdm", PDM_OUT, 1'b0);
    end

    // A continuous stream of 128 gives 32 ones per frame in a strictly alternating pattern.
    do_reset();
    EN = 1'b1; S_VALID = 1'b1; S_DATA = 8'd128;
    run_frames(2);
    for (int i = 0; i < 128; i++) begin
      prevbit = PDM_OUT;
      step();
      n_cmp++;
      assert (PDM_OUT !== prevbit) else begin
        n_bad++;
        $error("FAIL alt128 observed=%0b expected=%0b", PDM_OUT, !prevbit);
      end
    end
    run_frames(2);
    for (int i = 2; i < fr_ones.size(); i++) chk_rng("ones128", fr_ones[i], 32, 32);
    chk("und128", UNDERRUN, 1'b0);
    check_frames();

    // Stream 0 for four frames, then 255.
    do_reset();
    EN = 1'b1; S_VALID = 1'b1; S_DATA = 8'd0;
    run_frames(4);
    for (int i = 0; i < 4; i++) chk_rng("zero_frame", fr_ones[i], 0, 0);
    S_DATA = 8'd255;
    run_frames(9);
    check_frames();

    // Ramp from 0 to 64, then hold at 64.
    do_reset();
    EN = 1'b1; S_VALID = 1'b1; S_DATA = 8'd64;
    run_frames(3);
    chk_rng("ramp64", fr_ones[0], 7, 8);
    chk_rng("hold64", fr_ones[1], 16, 16);
    check_frames();

    // Backpressure while disabled: three samples back to back.
    do_reset();
    S_VALID = 1'b1; S_DATA = 8'd10;
    step();
    chk("bp_rdy1", S_READY, 1'b1);
    S_DATA = 8'd20;
    step();
    chk("bp_rdy2", S_READY, 1'b0);
    S_DATA = 8'd30;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", S_READY, 1'b0);
    end
    EN = 1'b1;
    step();
    chk("bp_after_load", S_READY, 1'b1);
    step();
    chk("bp_third_in", S_READY, 1'b0);
    S_VALID = 1'b0;
    run_frames(3);
    chk_rng("order_a", fr_cur[0], 10, 10);
    chk_rng("order_b", fr_cur[1], 20, 20);
    chk_rng("order_c", fr_cur[2], 30, 30);
    check_frames();

    // A single sample of 200, then underrun handling.
    do_reset();
    push_one(8'd200);
    EN = 1'b1;
    step();
    chk("und_first_load", UNDERRUN, 1'b0);
    run_frames(1);
    chk("und_second_load", UNDERRUN, 1'b1);
    run_frames(2);
    chk_rng("hold200_a", fr_ones[1], 50, 50);
    chk_rng("hold200_b", fr_ones[2], 50, 50);
    UNDERRUN_CLR = 1'b1;
    step();
    UNDERRUN_CLR = 1'b0;
    chk("und_cleared", UNDERRUN, 1'b0);
    repeat (10) step();
    chk("und_stays_clear", UNDERRUN, 1'b0);
    run_frames(1);
    chk("und_reset_by_load", UNDERRUN, 1'b1);
    check_frames();

    // Randomized traffic: busy source first, then a sparse one. Includes occasional enable toggles and clears.
    do_reset();
    EN = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      S_VALID = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) < 2);
      S_DATA = 8'($urandom_range(0, 255));
      UNDERRUN_CLR = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) EN = !EN;
      if (!EN && $urandom_range(0, 7) == 0) EN = 1'b1;
      step();
    end
    UNDERRUN_CLR = 1'b0;
    S_VALID = 1'b0;
    check_frames();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
